// File: rtl/fifo_burst_gather_pkg.sv
// Shared types and helpers for the burst gatherer that drains the prefetch FIFO
// into addressed DDR write bursts.
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned PAGE_BYTES     = 4096;

  function automatic logic [31:0] min3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/fifo_burst_gather_len_calc.sv
// Burst length for the next command: min(BURST_LEN, remaining, 4 KB guard) - 1.
// The guard term exists only when FIFO_BURST_GATHER_4K_GUARD_EN is defined.
module fifo_burst_len_calc
  import fifo_burst_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 20,
  parameter int BURST_LEN = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [CNT_W-1:0]  remaining,
  output logic [8:0]        cmd_len
);

  logic [31:0] rem_w;
  logic [31:0] guard_w;
  logic [31:0] beats;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr;

  always_comb begin
    // Saturate first so a counter wider than 32 bits cannot alias to a short burst.
    rem_w = (remaining >= CNT_W'(BURST_LEN)) ? 32'(BURST_LEN) : 32'(remaining);
`ifdef FIFO_BURST_GATHER_4K_GUARD_EN
    guard_w = (32'(PAGE_BYTES) - 32'(addr[11:0])) / 32'(BYTES_PER_WORD);
`else
    guard_w = 32'hFFFF_FFFF;
`endif
    beats   = min3(32'(BURST_LEN), rem_w, guard_w);
    cmd_len = 9'(beats - 32'd1);
  end

endmodule

// File: rtl/fifo_burst_gather.sv
// Regroups FIFO read words into addressed write bursts (command, then data beats).
// Optional 4 KB boundary split: define FIFO_BURST_GATHER_4K_GUARD_EN.
module fifo_burst_gather
  import fifo_burst_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  frame_words,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic              cmd_vld,
  input  logic              cmd_rdy,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [8:0]        cmd_len,
  output logic [DATA_W-1:0] wdata,
  output logic              wvld,
  input  logic              wrdy,
  output logic              wlast
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [8:0]        beat_cnt_q, beat_cnt_d;
  logic              cmd_vld_q, cmd_vld_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [8:0]        cmd_len_q, cmd_len_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [8:0]        next_len;
  logic              in_data;
  logic              beat_acc;

  // Sized from the next address/count so the command registers load on entry to CMD.
  fifo_burst_len_calc #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .BURST_LEN(BURST_LEN)
  ) u_len_calc (
    .addr     (addr_d),
    .remaining(rem_d),
    .cmd_len  (next_len)
  );

  assign in_data    = (state_q == ST_DATA);
  assign wvld       = in_data & fifo_rd_vld;
  assign wdata      = in_data ? fifo_rd_data : '0;
  assign wlast      = in_data & (beat_cnt_q == 9'd0);
  assign beat_acc   = wvld & wrdy;
  assign fifo_rd_en = beat_acc;

  always_comb begin
    // NOTE: every _d takes its hold value first so no path through the case leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = frame_words;
          if (frame_words == '0) done_d  = 1'b1;
          else                   state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cmd_vld_q && cmd_rdy) begin
          beat_cnt_d = cmd_len_q;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          rem_d      = rem_q - CNT_W'(1);
          if (wlast) begin
            addr_d = addr_q + ((ADDR_W'(cmd_len_q) + ADDR_W'(1)) * ADDR_W'(BYTES_PER_WORD));
            if (rem_q == CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_CMD;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d != ST_IDLE);
    cmd_vld_d  = (state_d == ST_CMD);
    cmd_addr_d = cmd_addr_q;
    cmd_len_d  = cmd_len_q;
    if ((state_d == ST_CMD) && (state_q != ST_CMD)) begin
      cmd_addr_d = addr_d;
      cmd_len_d  = next_len;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the asynchronous reset clears every register, including counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      beat_cnt_q <= '0;
      cmd_vld_q  <= 1'b0;
      cmd_addr_q <= '0;
      cmd_len_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beat_cnt_q <= beat_cnt_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_len_q  <= cmd_len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cmd_vld  = cmd_vld_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_len  = cmd_len_q;

endmodule
